// File: rtl/present_decrypt_core_if.sv
// Handshake bundle for present_decrypt_core: ciphertext/key in, plaintext out.
interface present_decrypt_core_if;
    localparam int unsigned SIZE     = 64;
    localparam int unsigned KEY_BITS = 80;

    logic                in_valid;
    logic                in_ready;
    logic [SIZE-1:0]     ciphertext;
    logic [KEY_BITS-1:0] key;
    logic                out_valid;
    logic                out_ready;
    logic [SIZE-1:0]     plaintext;
    logic                busy;

    // Job producer / plaintext consumer side.
    modport master (
        output in_valid, ciphertext, key, out_ready,
        input  in_ready, out_valid, plaintext, busy
    );

    // Decrypt core side.
    modport slave (
        input  in_valid, ciphertext, key, out_ready,
        output in_ready, out_valid, plaintext, busy
    );
endinterface

// File: rtl/present_decrypt_core.sv
// Iterative PRESENT-80 decryption: expand the key forward to K32, whiten,
// then unwind 31 rounds (inverse P-layer, inverse S-box layer, key XOR).
// Optional macro KEY_CACHE_EN: remembers the last expanded K32 and skips key
// expansion when the next job uses the same master key.
module present_decrypt_core (
    input logic                   clk,
    input logic                   reset,
    present_decrypt_core_if.slave bus
);
    localparam int unsigned SIZE     = 64;
    localparam int unsigned KEY_BITS = 80;
    localparam int unsigned ROUNDS   = 31;
    localparam int unsigned RC_W     = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYEXP,
        S_WHITEN,
        S_ROUND,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [SIZE-1:0]     data_q, data_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [RC_W-1:0]     rc_q, rc_d;
    logic [SIZE-1:0]     pt_q, pt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [KEY_BITS-1:0] key_fwd_c;
    logic [KEY_BITS-1:0] key_inv_c;
    logic [SIZE-1:0]     round_data_c;

`ifdef KEY_CACHE_EN
    logic [KEY_BITS-1:0] cached_key_q, cached_key_d;
    logic [KEY_BITS-1:0] cached_k32_q, cached_k32_d;
    logic                cache_valid_q, cache_valid_d;
`endif

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC; 4'h1: y = 4'h5; 4'h2: y = 4'h6; 4'h3: y = 4'hB;
            4'h4: y = 4'h9; 4'h5: y = 4'h0; 4'h6: y = 4'hA; 4'h7: y = 4'hD;
            4'h8: y = 4'h3; 4'h9: y = 4'hE; 4'hA: y = 4'hF; 4'hB: y = 4'h8;
            4'hC: y = 4'h4; 4'hD: y = 4'h7; 4'hE: y = 4'h1; default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5; 4'h1: y = 4'hE; 4'h2: y = 4'hF; 4'h3: y = 4'h8;
            4'h4: y = 4'hC; 4'h5: y = 4'h1; 4'h6: y = 4'h2; 4'h7: y = 4'hD;
            4'h8: y = 4'hB; 4'h9: y = 4'h4; 4'hA: y = 4'h6; 4'hB: y = 4'h3;
            4'hC: y = 4'h0; 4'hD: y = 4'h7; 4'hE: y = 4'h9; default: y = 4'hA;
        endcase
        return y;
    endfunction

    // Output bit j takes input bit 16*j mod 63; bit 63 is fixed.
    function automatic logic [SIZE-1:0] p_inv(input logic [SIZE-1:0] x);
        logic [SIZE-1:0] y;
        y = '0;
        for (int j = 0; j < 63; j++) begin
            y[6'(j)] = x[6'((16 * j) % 63)];
        end
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [SIZE-1:0] sinv_layer(input logic [SIZE-1:0] x);
        logic [SIZE-1:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[n*4 +: 4] = sbox_inv(x[n*4 +: 4]);
        end
        return y;
    endfunction

    // Forward schedule step: rotl61, S-box on top nibble, counter XOR.
    function automatic logic [KEY_BITS-1:0] key_step_fwd(input logic [KEY_BITS-1:0] k,
                                                        input logic [RC_W-1:0]     rc);
        logic [KEY_BITS-1:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ rc;
        return r;
    endfunction

    // Inverse schedule step: undo counter XOR, inverse S-box, rotr61.
    function automatic logic [KEY_BITS-1:0] key_step_inv(input logic [KEY_BITS-1:0] k,
                                                        input logic [RC_W-1:0]     rc);
        logic [KEY_BITS-1:0] r;
        r          = k;
        r[19:15]   = r[19:15] ^ rc;
        r[79:76]   = sbox_inv(r[79:76]);
        return {r[60:0], r[79:61]};
    endfunction

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        key_d        = key_q;
        rc_d         = rc_q;
        pt_d         = pt_q;
        key_fwd_c    = key_step_fwd(key_q, rc_q);
        key_inv_c    = key_step_inv(key_q, rc_q);
        round_data_c = sinv_layer(p_inv(data_q)) ^ key_inv_c[79:16];
`ifdef KEY_CACHE_EN
        cached_key_d  = cached_key_q;
        cached_k32_d  = cached_k32_q;
        cache_valid_d = cache_valid_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    data_d  = bus.ciphertext;
                    key_d   = bus.key;
                    rc_d    = RC_W'(1);
                    state_d = S_KEYEXP;
`ifdef KEY_CACHE_EN
                    if (cache_valid_q && (bus.key == cached_key_q)) begin
                        key_d   = cached_k32_q;
                        state_d = S_WHITEN;
                    end else begin
                        cached_key_d  = bus.key;
                        cache_valid_d = 1'b0;
                    end
`endif
                end
            end
            S_KEYEXP: begin
                key_d = key_fwd_c;
                if (rc_q == RC_W'(ROUNDS)) begin
                    state_d = S_WHITEN;
`ifdef KEY_CACHE_EN
                    cached_k32_d  = key_fwd_c;
                    cache_valid_d = 1'b1;
`endif
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            S_WHITEN: begin
                data_d  = data_q ^ key_q[79:16];
                rc_d    = RC_W'(ROUNDS);
                state_d = S_ROUND;
            end
            S_ROUND: begin
                key_d  = key_inv_c;
                data_d = round_data_c;
                if (rc_q == RC_W'(1)) begin
                    pt_d    = round_data_c;
                    state_d = S_DONE;
                end else begin
                    rc_d = rc_q - RC_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_KEYEXP) || (state_d == S_WHITEN) || (state_d == S_ROUND);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            key_q       <= '0;
            rc_q        <= '0;
            pt_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            key_q       <= key_d;
            rc_q        <= rc_d;
            pt_q        <= pt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef KEY_CACHE_EN
    // Expanded-key cache registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cached_key_q  <= '0;
            cached_k32_q  <= '0;
            cache_valid_q <= 1'b0;
        end else begin
            cached_key_q  <= cached_key_d;
            cached_k32_q  <= cached_k32_d;
            cache_valid_q <= cache_valid_d;
        end
    end
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.plaintext = pt_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_present_decrypt_core.sv
// Self-checking bench for present_decrypt_core. Expected plaintexts come from
// published PRESENT-80 vectors and from a forward-encryption model: random
// plaintexts are encrypted here and the core must recover them.
module tb_present_decrypt_core;
`ifdef KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic clk;
    logic reset;
    present_decrypt_core_if bus ();

    present_decrypt_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        cache_ok;
    logic [79:0] cache_key;

    logic [63:0] vec_ct  [4];
    logic [79:0] vec_key [4];
    logic [63:0] vec_pt  [4];

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] sb(input logic [3:0] x);
        logic [3:0] tbl [16];
        tbl = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        return tbl[x];
    endfunction

    // Reference PRESENT-80 encryption (forward direction).
    function automatic logic [63:0] encrypt(input logic [63:0] pt, input logic [79:0] mk);
        logic [63:0] rk [33];
        logic [79:0] k;
        logic [63:0] s, t;
        k = mk;
        for (int i = 1; i <= 32; i++) begin
            rk[i] = k[79:16];
            k = {k[18:0], k[79:19]};
            k[79:76] = sb(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(i);
        end
        s = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ rk[r];
            for (int n = 0; n < 16; n++) s[n*4 +: 4] = sb(s[n*4 +: 4]);
            t = '0;
            for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (16 * b) % 63] = s[b];
            s = t;
        end
        return s ^ rk[32];
    endfunction

    function automatic int exp_lat(input logic [79:0] k);
        return (CACHE && cache_ok && (k == cache_key)) ? 32 : 63;
    endfunction

    // One job from an idle core; bp = cycles of backpressure, pulse = stray in_valid.
    task automatic run_job(input string tag, input logic [63:0] ct, input logic [79:0] k,
                           input logic [63:0] pt, input int bp, input bit pulse);
        int lat;
        int n;
        lat = exp_lat(k);
        check_eq({tag, "/in_ready_idle"}, 80'(bus.in_ready), 80'(1));
        bus.in_valid   = 1'b1;
        bus.ciphertext = ct;
        bus.key        = k;
        bus.out_ready  = 1'b0;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.ciphertext = {$urandom(), $urandom()};
        bus.key        = 80'({$urandom(), $urandom(), $urandom()});
        check_eq({tag, "/busy"}, 80'({bus.busy, bus.in_ready}), 80'(2'b10));
        n = 0;
        while (!bus.out_valid && n < 200) begin
            bus.in_valid = pulse && (n == 5 || n == 40);
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        check_eq({tag, "/latency"}, 80'(n), 80'(lat));
        check_eq({tag, "/plaintext"}, 80'(bus.plaintext), 80'(pt));
        check_eq({tag, "/busy_done"}, 80'(bus.busy), 80'(0));
        for (int c = 0; c < bp; c++) begin
            @(posedge clk); #1;
            check_eq({tag, "/bp_valid_ready"}, 80'({bus.out_valid, bus.in_ready}), 80'(2'b10));
            check_eq({tag, "/bp_plaintext"}, 80'(bus.plaintext), 80'(pt));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_eq({tag, "/exit"}, 80'({bus.out_valid, bus.in_ready}), 80'(2'b01));
        cache_key = k;
        cache_ok  = 1'b1;
    endtask

    task automatic apply_reset();
        reset          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.ciphertext = '0;
        bus.key        = '0;
        cache_ok       = 1'b0;
        cache_key      = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset/outs", 80'({bus.in_ready, bus.out_valid, bus.busy}), 80'(3'b100));
        check_eq("reset/plaintext", 80'(bus.plaintext), 80'(0));
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [79:0] k;
        logic [63:0] pt;
        int n;
        vec_ct[0] = 64'h5579C1387B228445; vec_key[0] = 80'h0;                    vec_pt[0] = 64'h0;
        vec_ct[1] = 64'hE72C46C0F5945049; vec_key[1] = 80'hFFFFFFFFFFFFFFFFFFFF; vec_pt[1] = 64'h0;
        vec_ct[2] = 64'hA112FFC72F68417B; vec_key[2] = 80'h0;                    vec_pt[2] = 64'hFFFFFFFFFFFFFFFF;
        vec_ct[3] = 64'h3333DCD3213210D2; vec_key[3] = 80'hFFFFFFFFFFFFFFFFFFFF; vec_pt[3] = 64'hFFFFFFFFFFFFFFFF;

        apply_reset();

        // Known-answer vectors, cache hit on the second key-F job when enabled.
        run_job("kat0", vec_ct[0], vec_key[0], vec_pt[0], 0, 1'b0);
        run_job("kat1", vec_ct[1], vec_key[1], vec_pt[1], 0, 1'b0);
        run_job("kat3", vec_ct[3], vec_key[3], vec_pt[3], 0, 1'b0);
        run_job("bp20", vec_ct[2], vec_key[2], vec_pt[2], 20, 1'b0);
        run_job("pulse", vec_ct[0], vec_key[0], vec_pt[0], 1, 1'b1);

        // Asynchronous reset in the middle of a job.
        bus.in_valid   = 1'b1;
        bus.ciphertext = vec_ct[0];
        bus.key        = 80'h1234;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_eq("abort/outs", 80'({bus.in_ready, bus.out_valid, bus.busy}), 80'(3'b100));
        check_eq("abort/plaintext", 80'(bus.plaintext), 80'(0));
        cache_ok = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_job("post_abort", vec_ct[0], vec_key[0], vec_pt[0], 0, 1'b0);

        // Randomized jobs, sometimes reusing the previous key.
        k = 80'({$urandom(), $urandom(), $urandom()});
        for (int j = 0; j < 8; j++) begin
            if ($urandom_range(0, 2) != 0) k = 80'({$urandom(), $urandom(), $urandom()});
            pt = {$urandom(), $urandom()};
            run_job($sformatf("rand%0d", j), encrypt(pt, k), k, pt, int'($urandom_range(0, 3)), 1'b0);
        end

        // Back-to-back: in_valid and out_ready held high across four vectors.
        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b1;
        bus.ciphertext = vec_ct[0];
        bus.key        = vec_key[0];
        for (int v = 0; v < 4; v++) begin
            n = 0;
            while (!bus.out_valid && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            check_eq($sformatf("b2b%0d/latency", v), 80'(n), 80'(1 + exp_lat(vec_key[v])));
            check_eq($sformatf("b2b%0d/plaintext", v), 80'(bus.plaintext), 80'(vec_pt[v]));
            cache_key = vec_key[v];
            cache_ok  = 1'b1;
            if (v < 3) begin
                bus.ciphertext = vec_ct[v+1];
                bus.key        = vec_key[v+1];
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check_eq($sformatf("b2b%0d/single", v), 80'({bus.out_valid, bus.in_ready}), 80'(2'b01));
        end
        bus.out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/present_decrypt_core.md
Name: present_decrypt_core

Overview:
- Iterative PRESENT-80 decryption core; the inverse direction of the existing encryption datapath built around PLayer.
- Expands the 80-bit master key forward to round key K32, then unwinds 31 rounds: inverse P-layer, inverse S-box layer, round-key XOR.
- Sits beside the encrypt core in the crypto datapath.
- Uses valid/ready handshakes on both the ciphertext input side and the plaintext output side.

Parameters:
- SIZE, 64, block width in bits; fixed by PRESENT, and other values are unsupported.
- KEY_BITS, 80, master key width; only 80 is supported.
- ROUNDS, 31, number of PRESENT rounds; sets round counter width to 5 bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- in_valid  input  1  ciphertext and key are presented.
- in_ready  output  1  core can accept a job; high only in IDLE.
- ciphertext  input  SIZE  block to decrypt; sampled on the accept edge only.
- key  input  KEY_BITS  master key; sampled on the accept edge only.
- out_valid  output  1  plaintext is valid; high only in DONE.
- out_ready  input  1  consumer accepts plaintext.
- plaintext  output  SIZE  decrypted block; held stable while out_valid is high.
- busy  output  1  high in KEYEXP, WHITEN and ROUND.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - plaintext=0; state/key registers=0; round counter=0.
  - Reset asserted mid-job aborts the job; no output is produced.
- FSM:
  - IDLE -> KEYEXP on accept (in_valid & in_ready). On that edge: data_reg=ciphertext, key_reg=key, rc=1.
  - KEYEXP, one forward key update per edge:
    - key_reg = rotl61(key_reg);
    - key_reg[79:76] = S(key_reg[79:76]);
    - key_reg[19:15] ^= rc;
    - rc++.
    - After the edge with rc=31: key_reg holds the K32 register; go to WHITEN.
  - WHITEN, one edge: data_reg ^= key_reg[79:16]; rc=31; go to ROUND.
  - ROUND, one edge per round i = rc, counting 31 down to 1:
    - inverse key update: key_reg[19:15] ^= i; key_reg[79:76] = Sinv(key_reg[79:76]); key_reg = rotr61(key_reg);
    - data_reg = Sinv_layer(Pinv(data_reg)) ^ key_reg_next[79:16].
    - After the edge with i=1: plaintext=data_reg, go to DONE.
  - DONE: out_valid=1. DONE -> IDLE on the edge where out_ready=1.
- Pinv: inverse of the PRESENT bit permutation. Output bit j takes input bit P(j), where P(j) = 16*j mod 63 for j<63 and P(63)=63.
- Latency: out_valid rises on the 63rd rising edge after the accept edge (31 KEYEXP + 1 WHITEN + 31 ROUND).
- Input side:
  - in_ready=0 outside IDLE.
  - in_valid while busy is ignored; no queuing.
  - ciphertext/key changes after the accept edge have no effect.
- Output side:
  - out_valid and plaintext hold indefinitely under backpressure (out_ready=0).
  - out_ready while out_valid=0 has no effect.
  - A new job is accepted at the earliest on the edge after DONE exits.
- Counter: rc is 5 bits and never wraps during a job. The KEYEXP terminal value is 31 and the ROUND terminal value is 1.

Optional Feature:
- KEY_CACHE_EN defined:
  - Core keeps cached_key (80b), cached_k32 (80b) and cache_valid. All clear on reset.
  - On accept with key==cached_key and cache_valid=1: load key_reg=cached_k32 and skip KEYEXP (IDLE -> WHITEN).
  - Latency is then 32 edges.
  - On every KEYEXP completion: update cached_key and cached_k32, and set cache_valid=1.
- KEY_CACHE_EN undefined:
  - No cache registers.
  - Latency is always 63.

Test Plan:
- Ciphertext 5579C1387B228445, key 00000000000000000000 -> plaintext 0000000000000000; out_valid exactly 63 edges after accept.
- Ciphertext E72C46C0F5945049, key FFFFFFFFFFFFFFFFFFFF -> plaintext 0000000000000000; then ciphertext 3333DCD3213210D2 with the same key -> FFFFFFFFFFFFFFFF. Latency is 32 on the second job with KEY_CACHE_EN, 63 without.
- Ciphertext A112FFC72F68417B, key 0, out_ready held 0 for 20 cycles after out_valid -> plaintext FFFFFFFFFFFFFFFF stable throughout; in_ready=0 until the edge after out_ready=1.
- in_valid pulsed with a different ciphertext at cycles 5 and 40 of a job -> ignored; result still matches the first job.
- reset driven low asynchronously at cycle 40 of a job (between clock edges) -> all outputs 0 and in_ready=1 immediately. A following clean job with the first vector -> correct plaintext. With KEY_CACHE_EN, the cache is invalid after reset, so latency is 63.
- Back-to-back: out_ready tied 1 and in_valid tied 1 across four vectors -> four correct plaintexts, each out_valid a single cycle, each job accepted on the edge after DONE.
